dot_accum_fifo: RTL and testbench



---
 rtl/dot_accum_fifo.sv | 134 +++++++++++++
 tb/tb_dot_accum_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dot_accum_fifo.sv
// Accumulates per-beat partial sums into per-vector results and queues them in a small ready/valid FIFO.
// Optional macro ACC_SAT_EN: saturating accumulation with a per-result out_sat flag (default wraps modulo 2^ACC_W).
module dot_accum_fifo #(
  parameter int IN_W  = 18,
  parameter int ACC_W = 32,
  parameter int LEN_W = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_sum,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [LEN_W-1:0] out_len,
  output logic             out_sat,
  output logic             ovf_err,
  output logic             busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [ACC_W-1:0] r_acc;
  logic [LEN_W-1:0] r_len;
  logic [ACC_W-1:0] r_memAcc [DEPTH];
  logic [LEN_W-1:0] r_memLen [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W:0]   r_count;
  logic             r_ovf;

  logic [ACC_W-1:0] w_sum;
  logic [LEN_W-1:0] w_lenNext;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_wrEn;
  logic             w_nonEmpty;

`ifdef ACC_SAT_EN
  logic             r_sat;
  logic             r_memSat [DEPTH];
  logic [ACC_W:0]   w_sumWide;
  logic             w_satNext;

  // Once a vector has clamped, it stays pinned at the maximum until it completes.
  assign w_sumWide = {1'b0, r_acc} + (ACC_W+1)'(in_sum);
  assign w_satNext = r_sat | w_sumWide[ACC_W];
  assign w_sum     = w_satNext ? '1 : w_sumWide[ACC_W-1:0];
`else
  assign w_sum     = r_acc + ACC_W'(in_sum);
`endif

  assign w_lenNext  = (&r_len) ? r_len : r_len + LEN_W'(1);
  assign w_nonEmpty = (r_count != '0);
  assign w_push     = in_valid & in_last;
  assign w_pop      = w_nonEmpty & out_ready;
  assign w_full     = (r_count == FULL_CNT);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_wrEn     = w_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_len <= '0;
`ifdef ACC_SAT_EN
      r_sat <= 1'b0;
`endif
    end else if (in_valid) begin
      if (in_last) begin
        r_acc <= '0;
        r_len <= '0;
`ifdef ACC_SAT_EN
        r_sat <= 1'b0;
`endif
      end else begin
        r_acc <= w_sum;
        r_len <= w_lenNext;
`ifdef ACC_SAT_EN
        r_sat <= w_satNext;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wrEn) begin
      r_memAcc[r_wrPtr] <= w_sum;
      r_memLen[r_wrPtr] <= w_lenNext;
`ifdef ACC_SAT_EN
      r_memSat[r_wrPtr] <= w_satNext;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wrEn) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      if (w_wrEn && !w_pop) begin
        r_count <= r_count + (PTR_W+1)'(1);
      end else if (!w_wrEn && w_pop) begin
        r_count <= r_count - (PTR_W+1)'(1);
      end
      if (w_push && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign out_valid = w_nonEmpty;
  assign out_acc   = w_nonEmpty ? r_memAcc[r_rdPtr] : '0;
  assign out_len   = w_nonEmpty ? r_memLen[r_rdPtr] : '0;
`ifdef ACC_SAT_EN
  assign out_sat   = w_nonEmpty ? r_memSat[r_rdPtr] : 1'b0;
`else
  assign out_sat   = 1'b0;
`endif
  assign ovf_err   = r_ovf;
  assign busy      = (r_len != '0);

endmodule

// File: tb/tb_dot_accum_fifo.sv
// Scoreboard bench for dot_accum_fifo: directed vectors push expected results, a negedge monitor pops and compares.
module tb_dot_accum_fifo;

  typedef struct {
    longint acc;
    longint len;
    longint sat;
  } expT;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic [17:0] inSum;
  logic        inLast;
  logic        outValid;
  logic        outReady;
  logic [31:0] outAcc;
  logic [15:0] outLen;
  logic        outSat;
  logic        ovfErr;
  logic        busy;

  logic        v20;
  logic [17:0] s20;
  logic        l20;
  logic        outValid20;
  logic [19:0] outAcc20;
  logic [15:0] outLen20;
  logic        outSat20;
  logic        ovfErr20;
  logic        busy20;

  expT sb[$];
  int  passCnt = 0;
  int  checkCnt = 0;

  always #5 clk = ~clk;

  dot_accum_fifo dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_sum(inSum), .in_last(inLast),
    .out_valid(outValid), .out_ready(outReady), .out_acc(outAcc), .out_len(outLen),
    .out_sat(outSat), .ovf_err(ovfErr), .busy(busy)
  );

  dot_accum_fifo #(.ACC_W(20)) dut20 (
    .clk(clk), .rst(rst), .in_valid(v20), .in_sum(s20), .in_last(l20),
    .out_valid(outValid20), .out_ready(1'b1), .out_acc(outAcc20), .out_len(outLen20),
    .out_sat(outSat20), .ovf_err(ovfErr20), .busy(busy20)
  );

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checkCnt++;
    if (act == exp) passCnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Presents one beat for exactly one rising edge; returns #1 after that edge.
  task automatic applyStimulus(input logic v, input logic [17:0] s, input logic l);
    inValid = v;
    inSum   = s;
    inLast  = l;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    inLast  = 1'b0;
    inSum   = '0;
  endtask

  task automatic expectResult(input longint acc, input longint len);
    expT e;
    e.acc = acc;
    e.len = len;
    e.sat = 0;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
  endtask

  // Monitor: every accepted head must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && outValid && outReady) begin
      if (sb.size() == 0) begin
        checkCnt++;
        $display("[TB] FAIL unexpected_result: got acc %0d len %0d, expected none", outAcc, outLen);
      end else begin
        expT e;
        e = sb.pop_front();
        checkOutput("head_acc", longint'(outAcc), e.acc);
        checkOutput("head_len", longint'(outLen), e.len);
        checkOutput("head_sat", longint'(outSat), e.sat);
      end
    end
  end

  initial begin
    rst = 1'b1; inValid = 1'b0; inSum = '0; inLast = 1'b0; outReady = 1'b0;
    v20 = 1'b0; s20 = '0; l20 = 1'b0;
    idle(2);
    rst = 1'b0;
    checkOutput("rst_out_valid", longint'(outValid), 0);
    checkOutput("rst_out_acc", longint'(outAcc), 0);
    checkOutput("rst_out_len", longint'(outLen), 0);
    checkOutput("rst_out_sat", longint'(outSat), 0);
    checkOutput("rst_ovf_err", longint'(ovfErr), 0);
    checkOutput("rst_busy", longint'(busy), 0);

    // Single-beat vector: visible one cycle later, gone the cycle after.
    outReady = 1'b1;
    expectResult(260100, 1);
    applyStimulus(1'b1, 18'd260100, 1'b1);
    checkOutput("single_valid", longint'(outValid), 1);
    checkOutput("single_acc", longint'(outAcc), 260100);
    idle(1);
    checkOutput("single_drained", longint'(outValid), 0);

    // Four back-to-back beats.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 18'd260100, 1'b0);
      checkOutput("busy_mid_vector", longint'(busy), 1);
    end
    expectResult(1040400, 4);
    applyStimulus(1'b1, 18'd260100, 1'b1);
    checkOutput("busy_after_last", longint'(busy), 0);
    idle(2);

    // Backpressure: five results into a four-entry FIFO, the fifth is dropped.
    outReady = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) expectResult(i, 1);
      applyStimulus(1'b1, 18'(i), 1'b1);
      checkOutput("stall_head_acc", longint'(outAcc), 1);
    end
    checkOutput("stall_head_len", longint'(outLen), 1);
    checkOutput("ovf_set", longint'(ovfErr), 1);
    outReady = 1'b1;
    idle(8);
    checkOutput("drain_overflow_sb", longint'(sb.size()), 0);
    checkOutput("ovf_sticky", longint'(ovfErr), 1);

    // Full FIFO with simultaneous push and pop.
    pulseReset();
    checkOutput("ovf_cleared", longint'(ovfErr), 0);
    outReady = 1'b0;
    for (int i = 10; i <= 13; i++) begin
      expectResult(i, 1);
      applyStimulus(1'b1, 18'(i), 1'b1);
    end
    outReady = 1'b1;
    expectResult(7, 1);
    applyStimulus(1'b1, 18'd7, 1'b1);
    checkOutput("full_pushpop_no_ovf", longint'(ovfErr), 0);
    checkOutput("full_pushpop_head", longint'(outAcc), 11);
    idle(8);
    checkOutput("drain_full_sb", longint'(sb.size()), 0);

    // Reset mid-vector discards the partial sum.
    applyStimulus(1'b1, 18'd100, 1'b0);
    applyStimulus(1'b1, 18'd100, 1'b0);
    checkOutput("busy_before_rst", longint'(busy), 1);
    pulseReset();
    checkOutput("busy_after_rst", longint'(busy), 0);
    expectResult(9, 1);
    applyStimulus(1'b1, 18'd9, 1'b1);
    checkOutput("after_rst_acc", longint'(outAcc), 9);
    idle(4);
    checkOutput("after_rst_ovf", longint'(ovfErr), 0);
    checkOutput("drain_rst_sb", longint'(sb.size()), 0);

    // Narrow accumulator: five beats overflow 20 bits.
    for (int i = 1; i <= 5; i++) begin
      v20 = 1'b1;
      s20 = 18'd260100;
      l20 = (i == 5);
      @(posedge clk);
      #1;
    end
    v20 = 1'b0;
    l20 = 1'b0;
    checkOutput("acc20_valid", longint'(outValid20), 1);
    checkOutput("acc20_len", longint'(outLen20), 5);
`ifdef ACC_SAT_EN
    checkOutput("acc20_acc", longint'(outAcc20), 1048575);
    checkOutput("acc20_sat", longint'(outSat20), 1);
`else
    checkOutput("acc20_acc", longint'(outAcc20), 251924);
    checkOutput("acc20_sat", longint'(outSat20), 0);
`endif
    idle(2);
    checkOutput("final_sb_empty", longint'(sb.size()), 0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
